// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM arbiter: command owner, FSM state
// and the refresh credit ceiling.
package vram_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_VDP,
      OWN_AUX,
      OWN_REF
   } owner_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUED,
      BUSY,
      DONE
   } state_t;

   localparam int         CREDIT_W   = 3;
   localparam logic [2:0] CREDIT_MAX = 3'd7;

endpackage

// File: rtl/vram_refresh_credit.sv
// Refresh bookkeeping: a free-running interval counter earns one credit per
// wrap into a saturating 3-bit bucket; each issued refresh spends one.
module vram_refresh_credit
   import vram_arb_pkg::*;
#(
   parameter int REFRESH_INTERVAL = 810,
   parameter int REFRESH_URGENT   = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic take,
   output logic credit_due,
   output logic credit_urgent,
   output logic overrun
);

   localparam int IW = $clog2(REFRESH_INTERVAL);

   logic [IW-1:0]       interval_reg;
   logic [CREDIT_W-1:0] credit_reg;
   logic                overrun_reg;
   logic                wrap;

   assign wrap          = (interval_reg == IW'(REFRESH_INTERVAL - 1));
   assign credit_due    = (credit_reg != '0);
   assign credit_urgent = (credit_reg >= CREDIT_W'(REFRESH_URGENT));
   assign overrun       = overrun_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         interval_reg <= '0;
         credit_reg   <= '0;
         overrun_reg  <= 1'b0;
      end else begin
         interval_reg <= wrap ? '0 : interval_reg + IW'(1);
         // An earn and a spend in the same cycle cancel out.
         case ({wrap, take})
            2'b10: if (credit_reg != CREDIT_MAX) credit_reg <= credit_reg + CREDIT_W'(1);
            2'b01: if (credit_reg != '0)         credit_reg <= credit_reg - CREDIT_W'(1);
            default: ;
         endcase
         if (wrap && credit_reg == CREDIT_MAX)
            overrun_reg <= 1'b1;
      end
   end

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates VDP, auxiliary and refresh traffic onto the single SDRAM
// memory_controller port, one command at a time.
module vram_arbiter
   import vram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH       = 21,
   parameter int REFRESH_INTERVAL = 810,
   parameter int REFRESH_URGENT   = 4,
   parameter int BUSY_TIMEOUT     = 15
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  vdp_req,
   input  logic                  vdp_wr,
   input  logic [ADDR_WIDTH-1:0] vdp_addr,
   input  logic [15:0]           vdp_din,
   input  logic [1:0]            vdp_wdm,
   output logic [15:0]           vdp_dout,
   output logic                  vdp_ack,
   input  logic                  aux_req,
   input  logic                  aux_wr,
   input  logic [ADDR_WIDTH-1:0] aux_addr,
   input  logic [15:0]           aux_din,
   input  logic [1:0]            aux_wdm,
   output logic [15:0]           aux_dout,
   output logic                  aux_ack,
   output logic                  mc_read,
   output logic                  mc_write,
   output logic                  mc_refresh,
   output logic [ADDR_WIDTH-1:0] mc_addr,
   output logic [15:0]           mc_din,
   output logic [1:0]            mc_wdm,
   input  logic [15:0]           mc_dout,
   input  logic                  mc_busy,
   output logic                  ref_overrun,
   output logic                  mc_timeout
);

   localparam int TW = $clog2(BUSY_TIMEOUT + 1);

   state_t          state_reg;
   owner_t          owner_reg;
   logic            wr_reg;
   logic [TW-1:0]   tmo_reg;

   logic            credit_due, credit_urgent;
   logic            idle_free, grant_ref, grant_vdp, grant_aux, grant_cmd, finish;
   logic            sel_wr;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [15:0]     sel_din;
   logic [1:0]      sel_wdm;

   vram_refresh_credit #(
      .REFRESH_INTERVAL (REFRESH_INTERVAL),
      .REFRESH_URGENT   (REFRESH_URGENT)
   ) u_credit (
      .clk           (clk),
      .reset_n       (reset_n),
      .take          (grant_ref),
      .credit_due    (credit_due),
      .credit_urgent (credit_urgent),
      .overrun       (ref_overrun)
   );

   // Urgent refresh > VDP > routine refresh > aux.
   assign idle_free = (state_reg == IDLE) && !mc_busy;
   assign grant_ref = idle_free && (credit_urgent || (!vdp_req && credit_due));
   assign grant_vdp = idle_free && !credit_urgent && vdp_req;
   assign grant_aux = idle_free && !credit_due && !vdp_req && aux_req;
   assign grant_cmd = grant_vdp || grant_aux;

   assign sel_wr   = grant_vdp ? vdp_wr   : aux_wr;
   assign sel_addr = grant_vdp ? vdp_addr : aux_addr;
   assign sel_din  = grant_vdp ? vdp_din  : aux_din;
   assign sel_wdm  = grant_vdp ? vdp_wdm  : aux_wdm;

   // Command completes either by busy falling or by the busy-assert watchdog.
   assign finish = ((state_reg == ISSUED) && !mc_busy && (tmo_reg == TW'(BUSY_TIMEOUT - 1)))
                || ((state_reg == BUSY) && !mc_busy);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg  <= IDLE;
         owner_reg  <= OWN_NONE;
         wr_reg     <= 1'b0;
         tmo_reg    <= '0;
         mc_read    <= 1'b0;
         mc_write   <= 1'b0;
         mc_refresh <= 1'b0;
         mc_addr    <= '0;
         mc_din     <= '0;
         mc_wdm     <= '0;
         vdp_ack    <= 1'b0;
         aux_ack    <= 1'b0;
         vdp_dout   <= '0;
         aux_dout   <= '0;
         mc_timeout <= 1'b0;
      end else begin
         mc_read    <= 1'b0;
         mc_write   <= 1'b0;
         mc_refresh <= 1'b0;
         vdp_ack    <= 1'b0;
         aux_ack    <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (grant_ref) begin
                  mc_refresh <= 1'b1;
                  owner_reg  <= OWN_REF;
                  wr_reg     <= 1'b0;
                  tmo_reg    <= '0;
                  state_reg  <= ISSUED;
               end else if (grant_cmd) begin
                  mc_read    <= ~sel_wr;
                  mc_write   <= sel_wr;
                  mc_addr    <= sel_addr;
                  mc_din     <= sel_din;
                  mc_wdm     <= sel_wdm;
                  owner_reg  <= grant_vdp ? OWN_VDP : OWN_AUX;
                  wr_reg     <= sel_wr;
                  tmo_reg    <= '0;
                  state_reg  <= ISSUED;
               end
            end
            ISSUED: begin
               if (mc_busy) begin
                  state_reg <= BUSY;
               end else if (finish) begin
                  mc_timeout <= 1'b1;
                  state_reg  <= DONE;
               end else begin
                  tmo_reg <= tmo_reg + TW'(1);
               end
            end
            BUSY: begin
               if (finish) state_reg <= DONE;
            end
            DONE: begin
               state_reg <= IDLE;
               owner_reg <= OWN_NONE;
            end
            default: state_reg <= IDLE;
         endcase
         // Ack and read data are registered on entry to DONE so they are valid during it.
         if (finish) begin
            if (owner_reg == OWN_VDP) begin
               vdp_ack <= 1'b1;
               if (!wr_reg) vdp_dout <= mc_dout;
            end
            if (owner_reg == OWN_AUX) begin
               aux_ack <= 1'b1;
               if (!wr_reg) aux_dout <= mc_dout;
            end
         end
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a small memory_controller busy model;
// every scenario task checks its own hand-computed expectations.
module tb_vram_arbiter;

   localparam int AW       = 21;
   localparam int INTERVAL = 810;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          vdp_req = 1'b0, vdp_wr = 1'b0;
   logic [AW-1:0] vdp_addr = '0;
   logic [15:0]   vdp_din = '0;
   logic [1:0]    vdp_wdm = '0;
   logic [15:0]   vdp_dout;
   logic          vdp_ack;
   logic          aux_req = 1'b0, aux_wr = 1'b0;
   logic [AW-1:0] aux_addr = '0;
   logic [15:0]   aux_din = '0;
   logic [1:0]    aux_wdm = '0;
   logic [15:0]   aux_dout;
   logic          aux_ack;
   logic          mc_read, mc_write, mc_refresh;
   logic [AW-1:0] mc_addr;
   logic [15:0]   mc_din;
   logic [1:0]    mc_wdm;
   logic [15:0]   mc_dout = '0;
   logic          mc_busy = 1'b0;
   logic          ref_overrun, mc_timeout;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // busy model: busy is high model_len cycles, starting model_dly cycles after the strobe
   int   model_dly = 2;
   int   model_len = 6;
   int   model_k   = 0;
   logic model_active = 1'b0;

   always #5 clk = ~clk;

   vram_arbiter #(
      .ADDR_WIDTH(AW), .REFRESH_INTERVAL(INTERVAL), .REFRESH_URGENT(4), .BUSY_TIMEOUT(15)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .vdp_req(vdp_req), .vdp_wr(vdp_wr), .vdp_addr(vdp_addr), .vdp_din(vdp_din),
      .vdp_wdm(vdp_wdm), .vdp_dout(vdp_dout), .vdp_ack(vdp_ack),
      .aux_req(aux_req), .aux_wr(aux_wr), .aux_addr(aux_addr), .aux_din(aux_din),
      .aux_wdm(aux_wdm), .aux_dout(aux_dout), .aux_ack(aux_ack),
      .mc_read(mc_read), .mc_write(mc_write), .mc_refresh(mc_refresh),
      .mc_addr(mc_addr), .mc_din(mc_din), .mc_wdm(mc_wdm),
      .mc_dout(mc_dout), .mc_busy(mc_busy),
      .ref_overrun(ref_overrun), .mc_timeout(mc_timeout)
   );

   always @(negedge clk) begin
      if (mc_read || mc_write || mc_refresh) begin
         model_active = 1'b1;
         model_k      = 0;
      end else if (model_active) begin
         model_k = model_k + 1;
         if (model_k > 60) model_active = 1'b0;
      end
      mc_busy = model_active && (model_k >= model_dly) && (model_k < model_dly + model_len);
   end

   task automatic tick();
      @(negedge clk);
      cyc = cyc + 1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      vdp_req = 1'b0;
      aux_req = 1'b0;
      #2;
      model_active = 1'b0;
      mc_busy      = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      cyc     = 0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if ({mc_read, mc_write, mc_refresh, vdp_ack, aux_ack, ref_overrun, mc_timeout} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 0000000",
                  {mc_read, mc_write, mc_refresh, vdp_ack, aux_ack, ref_overrun, mc_timeout});
      end
      n_checks++;
      if ({mc_addr, mc_din, mc_wdm, vdp_dout, aux_dout} !== '0) begin
         n_fail++;
         $display("FAIL reset_buses: addr %h din %h wdm %b vdout %h adout %h expected all 0",
                  mc_addr, mc_din, mc_wdm, vdp_dout, aux_dout);
      end
      $display("reset: outputs checked in reset");
   endtask

   task automatic test_vdp_read();
      int n_rd = 0, n_other = 0, n_ack = 0, n_aux = 0, t_strobe = -1, t_ack = -1;
      logic [AW-1:0] a_seen = '0;
      logic [15:0]   d_seen = '0;
      do_reset();
      model_dly = 2; model_len = 6; mc_dout = 16'hBEEF;
      vdp_wr = 1'b0; vdp_addr = 21'h01234; vdp_req = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (mc_read) begin
            n_rd++;
            if (t_strobe < 0) begin t_strobe = cyc; a_seen = mc_addr; end
         end
         if (mc_write || mc_refresh) n_other++;
         if (aux_ack) n_aux++;
         if (vdp_ack) begin n_ack++; t_ack = cyc; d_seen = vdp_dout; vdp_req = 1'b0; end
      end
      $display("vdp_read: strobe@%0d addr %h ack@%0d data %h", t_strobe, a_seen, t_ack, d_seen);
      n_checks++; if (n_rd !== 1) begin n_fail++; $display("FAIL vdp_read_pulses: got %0d expected 1", n_rd); end
      n_checks++; if (t_strobe !== 1) begin n_fail++; $display("FAIL vdp_read_strobe_time: got %0d expected 1", t_strobe); end
      n_checks++; if (a_seen !== 21'h01234) begin n_fail++; $display("FAIL vdp_read_addr: got %h expected 01234", a_seen); end
      n_checks++; if (t_ack !== 10) begin n_fail++; $display("FAIL vdp_read_ack_time: got %0d expected 10", t_ack); end
      n_checks++; if (d_seen !== 16'hBEEF) begin n_fail++; $display("FAIL vdp_read_data: got %h expected beef", d_seen); end
      n_checks++; if (n_ack !== 1 || n_other !== 0 || n_aux !== 0) begin
         n_fail++; $display("FAIL vdp_read_side: acks %0d other %0d aux %0d expected 1 0 0", n_ack, n_other, n_aux);
      end
      n_checks++; if (vdp_dout !== 16'hBEEF) begin n_fail++; $display("FAIL vdp_dout_hold: got %h expected beef", vdp_dout); end
   endtask

   task automatic test_contention();
      int t_rd = -1, t_wr = -1, t_vack = -1, t_aack = -1, n_vack = 0, n_aack = 0;
      logic [AW-1:0] rd_addr = '0, wr_addr = '0;
      logic [15:0]   wr_din = '0;
      logic [1:0]    wr_wdm = '0;
      do_reset();
      mc_dout = 16'h1357;
      vdp_wr = 1'b0; vdp_addr = 21'h00100;
      aux_wr = 1'b1; aux_addr = 21'h1ABCD; aux_din = 16'h55AA; aux_wdm = 2'b01;
      vdp_req = 1'b1; aux_req = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (mc_read && t_rd < 0) begin t_rd = cyc; rd_addr = mc_addr; end
         if (mc_write && t_wr < 0) begin t_wr = cyc; wr_addr = mc_addr; wr_din = mc_din; wr_wdm = mc_wdm; end
         if (vdp_ack) begin n_vack++; t_vack = cyc; vdp_req = 1'b0; end
         if (aux_ack) begin n_aack++; t_aack = cyc; aux_req = 1'b0; end
      end
      $display("contention: vdp rd@%0d ack@%0d, aux wr@%0d din %h wdm %b ack@%0d", t_rd, t_vack, t_wr, wr_din, wr_wdm, t_aack);
      n_checks++; if (t_rd !== 1 || rd_addr !== 21'h00100) begin n_fail++; $display("FAIL cont_vdp_first: t %0d addr %h expected 1 00100", t_rd, rd_addr); end
      n_checks++; if (t_vack !== 10) begin n_fail++; $display("FAIL cont_vdp_ack: got %0d expected 10", t_vack); end
      n_checks++; if (t_wr !== 12 || wr_addr !== 21'h1ABCD) begin n_fail++; $display("FAIL cont_aux_issue: t %0d addr %h expected 12 1abcd", t_wr, wr_addr); end
      n_checks++; if (wr_din !== 16'h55AA || wr_wdm !== 2'b01) begin n_fail++; $display("FAIL cont_aux_data: din %h wdm %b expected 55aa 01", wr_din, wr_wdm); end
      n_checks++; if (t_aack !== 21 || n_aack !== 1 || n_vack !== 1) begin
         n_fail++; $display("FAIL cont_acks: aux@%0d n_aux %0d n_vdp %0d expected 21 1 1", t_aack, n_aack, n_vack);
      end
      n_checks++; if (vdp_dout !== 16'h1357 || aux_dout !== 16'h0000) begin
         n_fail++; $display("FAIL cont_dout: vdp %h aux %h expected 1357 0000", vdp_dout, aux_dout);
      end
      aux_wr = 1'b0;
   endtask

   task automatic test_aux_read();
      int t_ack = -1, n_ack = 0;
      do_reset();
      mc_dout = 16'hA5C3;
      aux_wr = 1'b0; aux_addr = 21'h00ABC; aux_req = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (aux_ack) begin n_ack++; t_ack = cyc; aux_req = 1'b0; end
      end
      $display("aux_read: ack@%0d data %h", t_ack, aux_dout);
      n_checks++; if (t_ack !== 10 || n_ack !== 1) begin n_fail++; $display("FAIL aux_read_ack: t %0d n %0d expected 10 1", t_ack, n_ack); end
      n_checks++; if (aux_dout !== 16'hA5C3 || vdp_dout !== 16'h0000) begin
         n_fail++; $display("FAIL aux_read_data: aux %h vdp %h expected a5c3 0000", aux_dout, vdp_dout);
      end
   endtask

   task automatic test_refresh_idle();
      int n_ref = 0, n_ack = 0;
      int t_ref[3] = '{-1, -1, -1};
      do_reset();
      for (int i = 0; i < 3 * INTERVAL + 20; i++) begin
         tick();
         if (mc_refresh) begin
            if (n_ref < 3) t_ref[n_ref] = cyc;
            n_ref++;
            $display("refresh_idle: refresh strobe @%0d", cyc);
         end
         if (vdp_ack || aux_ack) n_ack++;
      end
      n_checks++; if (n_ref !== 3) begin n_fail++; $display("FAIL refresh_count: got %0d expected 3", n_ref); end
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (t_ref[k] !== INTERVAL * (k + 1) + 1) begin
            n_fail++; $display("FAIL refresh_time_%0d: got %0d expected %0d", k, t_ref[k], INTERVAL * (k + 1) + 1);
         end
      end
      n_checks++; if (dut.u_credit.credit_reg !== 3'd0) begin n_fail++; $display("FAIL refresh_credit_empty: got %0d expected 0", dut.u_credit.credit_reg); end
      n_checks++; if (n_ack !== 0) begin n_fail++; $display("FAIL refresh_no_ack: got %0d expected 0", n_ack); end
   endtask

   task automatic test_back_to_back();
      int n_ref = 0, n_vack = 0, t_first = -1;
      do_reset();
      mc_dout = 16'h2468;
      vdp_wr = 1'b0; vdp_addr = 21'h00200; vdp_req = 1'b1;
      while (cyc < 3270) begin
         tick();
         if (mc_refresh) begin
            n_ref++;
            if (t_first < 0) t_first = cyc;
            $display("back_to_back: refresh strobe @%0d", cyc);
         end
         if (vdp_ack) n_vack++;
      end
      vdp_req = 1'b0;
      $display("back_to_back: %0d vdp acks, first refresh @%0d", n_vack, t_first);
      n_checks++; if (t_first !== 3246) begin n_fail++; $display("FAIL b2b_first_refresh: got %0d expected 3246", t_first); end
      n_checks++; if (n_ref !== 1) begin n_fail++; $display("FAIL b2b_refresh_count: got %0d expected 1", n_ref); end
      n_checks++; if (n_vack !== 296) begin n_fail++; $display("FAIL b2b_vdp_acks: got %0d expected 296", n_vack); end
      n_checks++; if (ref_overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b expected 0", ref_overrun); end
   endtask

   task automatic test_timeout();
      int t_wr = -1, t_ack = -1, t_ack2 = -1, base;
      logic [15:0] din_seen = '0;
      logic        tmo15 = 1'bx, tmo16 = 1'bx;
      do_reset();
      model_len = 0;
      vdp_wr = 1'b1; vdp_addr = 21'h00042; vdp_din = 16'h1234; vdp_wdm = 2'b00; vdp_req = 1'b1;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (mc_write && t_wr < 0) begin t_wr = cyc; din_seen = mc_din; end
         if (cyc == 15) tmo15 = mc_timeout;
         if (cyc == 16) tmo16 = mc_timeout;
         if (vdp_ack) begin t_ack = cyc; vdp_req = 1'b0; end
      end
      $display("timeout: write@%0d din %h timeout %b->%b ack@%0d", t_wr, din_seen, tmo15, tmo16, t_ack);
      n_checks++; if (t_wr !== 1 || din_seen !== 16'h1234) begin n_fail++; $display("FAIL tmo_write: t %0d din %h expected 1 1234", t_wr, din_seen); end
      n_checks++; if (tmo15 !== 1'b0 || tmo16 !== 1'b1) begin n_fail++; $display("FAIL tmo_flag: @15 %b @16 %b expected 0 1", tmo15, tmo16); end
      n_checks++; if (t_ack !== 16) begin n_fail++; $display("FAIL tmo_ack: got %0d expected 16", t_ack); end
      model_len = 6;
      mc_dout = 16'h0F0F;
      vdp_wr = 1'b0; vdp_addr = 21'h00043; vdp_req = 1'b1;
      base = cyc;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (vdp_ack) begin t_ack2 = cyc; vdp_req = 1'b0; end
      end
      $display("timeout: follow-up read ack@%0d data %h", t_ack2, vdp_dout);
      n_checks++; if (t_ack2 !== base + 10 || vdp_dout !== 16'h0F0F) begin
         n_fail++; $display("FAIL tmo_recover: ack@%0d data %h expected %0d 0f0f", t_ack2, vdp_dout, base + 10);
      end
      n_checks++; if (mc_timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b expected 1", mc_timeout); end
   endtask

   task automatic test_reset_mid_busy();
      int t_rd = -1, n_ack = 0, n_early = 0, n_wr = 0, t_ack = -1;
      logic [AW-1:0] rd_addr = '0;
      do_reset();
      mc_dout = 16'h7777;
      vdp_wr = 1'b0; vdp_addr = 21'h00777; vdp_req = 1'b1;
      repeat (5) tick();
      n_checks++; if (mc_addr !== 21'h00777) begin n_fail++; $display("FAIL midrst_pre_addr: got %h expected 00777", mc_addr); end
      reset_n = 1'b0;
      #1;
      n_checks++; if ({mc_read, mc_write, mc_refresh, vdp_ack, aux_ack, mc_timeout, ref_overrun} !== 7'b0 ||
                      mc_addr !== '0 || vdp_dout !== '0) begin
         n_fail++; $display("FAIL midrst_async: flags %b addr %h dout %h expected 0",
                            {mc_read, mc_write, mc_refresh, vdp_ack, aux_ack, mc_timeout, ref_overrun}, mc_addr, vdp_dout);
      end
      vdp_addr = 21'h00999;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      cyc = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (mc_read && t_rd < 0) begin t_rd = cyc; rd_addr = mc_addr; end
         if (mc_write) n_wr++;
         if (vdp_ack) begin
            n_ack++; t_ack = cyc; vdp_req = 1'b0;
            if (t_rd < 0) n_early++;
         end
      end
      $display("reset_mid_busy: first read@%0d addr %h ack@%0d", t_rd, rd_addr, t_ack);
      n_checks++; if (t_rd < 0 || rd_addr !== 21'h00999 || n_wr !== 0) begin
         n_fail++; $display("FAIL midrst_grant: t %0d addr %h writes %0d expected addr 00999 no writes", t_rd, rd_addr, n_wr);
      end
      n_checks++; if (n_early !== 0 || n_ack !== 1 || t_ack !== t_rd + 9) begin
         n_fail++; $display("FAIL midrst_ack: early %0d acks %0d ack@%0d expected 0 1 %0d", n_early, n_ack, t_ack, t_rd + 9);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_vdp_read();
      test_contention();
      test_aux_read();
      test_refresh_idle();
      test_back_to_back();
      test_timeout();
      test_reset_mid_busy();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
